// File: rtl/fabric_sched_pkg.sv
// fabric_sched_pkg: shared scheduler state encoding, default limits and port index type
package fabric_sched_pkg;
  typedef enum logic {IDLE, BUSY} sched_state_t;
  localparam int TIMEOUT_CYCLES_DEF = 4096;
  localparam int STARVE_LIMIT_DEF = 8;
  localparam int PORT_BITS_DEF = 5;
  typedef logic [PORT_BITS_DEF-1:0] port_t;
endpackage

// File: rtl/rr_select.sv
// rr_select: first set request bit at or after ptr, wrapping at NUM_PORTS
module rr_select #(
  parameter int NUM_PORTS = 28,
  parameter int PORT_BITS = 5
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_BITS-1:0] ptr,
  output logic                 found,
  output logic [PORT_BITS-1:0] index,
  output logic [NUM_PORTS-1:0] onehot
);
  logic                 hi_found;
  logic [PORT_BITS-1:0] hi_idx;
  logic [PORT_BITS-1:0] lo_idx;
  // scan downward so the lowest qualifying bit wins; hi_* covers index >= ptr, lo_* is the wrap fallback
  always_comb begin
    hi_found = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) lo_idx = PORT_BITS'(i);
      if (req[i] && i >= int'(ptr)) begin
        hi_found = 1'b1;
        hi_idx = PORT_BITS'(i);
      end
    end
    found = |req;
    index = hi_found ? hi_idx : lo_idx;
    onehot = found ? (NUM_PORTS'(1) << index) : '0;
  end
endmodule

// File: rtl/ingress_port_scheduler.sv
// ingress_port_scheduler: two-class round-robin frame grant with watchdog and low-class anti-starvation
module ingress_port_scheduler
  import fabric_sched_pkg::*;
#(
  parameter int NUM_PORTS      = 28,
  parameter int PORT_BITS      = 5,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] port_req,
  input  logic [NUM_PORTS-1:0] port_en,
  input  logic [NUM_PORTS-1:0] prio_mask,
  input  logic                 tx_ready,
  input  logic                 frame_done,
  output logic                 grant_valid,
  output logic [PORT_BITS-1:0] grant_port,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic                 timeout,
  output logic                 spurious_done,
  output logic [31:0]          grant_count
);
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  sched_state_t         state;
  logic [PORT_BITS-1:0] hi_ptr, lo_ptr;
  logic [SCW-1:0]       starve_cnt;
  logic [WDW-1:0]       wd_cnt;
  logic [NUM_PORTS-1:0] elig, hi, lo;
  logic                 hi_found, lo_found, use_hi;
  logic [PORT_BITS-1:0] hi_idx, lo_idx, win_idx, nxt_ptr;
  logic [NUM_PORTS-1:0] hi_oh, lo_oh, win_oh;
  rr_select #(.NUM_PORTS(NUM_PORTS), .PORT_BITS(PORT_BITS)) u_hi (
    .req(hi), .ptr(hi_ptr), .found(hi_found), .index(hi_idx), .onehot(hi_oh)
  );
  rr_select #(.NUM_PORTS(NUM_PORTS), .PORT_BITS(PORT_BITS)) u_lo (
    .req(lo), .ptr(lo_ptr), .found(lo_found), .index(lo_idx), .onehot(lo_oh)
  );
  // class choice: high class wins unless low has been passed over STARVE_LIMIT times in a row
  always_comb begin
    elig = port_req & port_en;
    hi = elig & prio_mask;
    lo = elig & ~prio_mask;
    use_hi = hi_found && (!lo_found || starve_cnt < SCW'(STARVE_LIMIT));
    win_idx = use_hi ? hi_idx : lo_idx;
    win_oh = use_hi ? hi_oh : lo_oh;
    nxt_ptr = (win_idx == PORT_BITS'(NUM_PORTS - 1)) ? '0 : win_idx + PORT_BITS'(1);
  end
  // grant FSM: issue in IDLE, hold through BUSY until frame_done or watchdog expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant_valid <= 1'b0;
      grant_port <= '0;
      grant_onehot <= '0;
      timeout <= 1'b0;
      spurious_done <= 1'b0;
      grant_count <= '0;
      hi_ptr <= '0;
      lo_ptr <= '0;
      starve_cnt <= '0;
      wd_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      spurious_done <= 1'b0;
      if (state == IDLE) begin
        spurious_done <= frame_done;
        if ((hi_found || lo_found) && tx_ready) begin
          state <= BUSY;
          grant_valid <= 1'b1;
          grant_port <= win_idx;
          grant_onehot <= win_oh;
          grant_count <= grant_count + 32'd1;
          wd_cnt <= '0;
          if (use_hi) hi_ptr <= nxt_ptr;
          else lo_ptr <= nxt_ptr;
          starve_cnt <= !(use_hi && lo_found) ? '0 :
                        (starve_cnt == SCW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + SCW'(1);
        end
      end else if (frame_done || wd_cnt == WDW'(TIMEOUT_CYCLES - 1)) begin
        state <= IDLE;
        grant_valid <= 1'b0;
        grant_onehot <= '0;
        timeout <= !frame_done;
      end else begin
        wd_cnt <= wd_cnt + WDW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ingress_port_scheduler.sv
// tb_ingress_port_scheduler: directed checks of grant order, starvation, watchdog, spurious done and async reset
module tb_ingress_port_scheduler;
  localparam int N = 28;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] port_req = '0, port_en = '0, prio_mask = '0;
  logic         tx_ready = 1'b0, frame_done = 1'b0;
  logic         grant_valid, timeout, spurious_done;
  logic [4:0]   grant_port;
  logic [N-1:0] grant_onehot;
  logic [31:0]  grant_count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ingress_port_scheduler dut (
    .clk(clk), .rst_n(rst_n), .port_req(port_req), .port_en(port_en), .prio_mask(prio_mask),
    .tx_ready(tx_ready), .frame_done(frame_done), .grant_valid(grant_valid), .grant_port(grant_port),
    .grant_onehot(grant_onehot), .timeout(timeout), .spurious_done(spurious_done), .grant_count(grant_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    port_req = '0;
    prio_mask = '0;
    frame_done = 1'b0;
    step;
    step;
    rst_n = 1'b1;
  endtask
  task automatic wait_grant(output int p);
    int k = 0;
    while (!grant_valid && k < 20) begin
      step;
      k++;
    end
    chk("grant_seen", 32'(grant_valid), 32'd1);
    p = int'(grant_port);
  endtask
  task automatic serve(output int p);
    wait_grant(p);
    frame_done = 1'b1;
    step;
    frame_done = 1'b0;
  endtask
  initial begin
    int p, k;
    logic [N-1:0] all_ports;
    all_ports = '1;
    step;
    chk("rst_gv", 32'(grant_valid), 0);
    chk("rst_gp", 32'(grant_port), 0);
    chk("rst_oh", 32'(grant_onehot), 0);
    chk("rst_cnt", grant_count, 0);
    chk("rst_to", 32'(timeout), 0);
    chk("rst_sp", 32'(spurious_done), 0);
    do_reset;
    port_en = all_ports;
    tx_ready = 1'b1;
    port_req = N'(1) << 3;
    step;
    chk("t1_gv", 32'(grant_valid), 1);
    chk("t1_gp", 32'(grant_port), 3);
    chk("t1_oh", 32'(grant_onehot), 32'h8);
    chk("t1_cnt", grant_count, 1);
    port_req = '0;
    frame_done = 1'b1;
    step;
    frame_done = 1'b0;
    chk("t1_drop_gv", 32'(grant_valid), 0);
    chk("t1_drop_oh", 32'(grant_onehot), 0);
    chk("t1_hold_gp", 32'(grant_port), 3);
    do_reset;
    port_req = all_ports;
    for (int i = 0; i <= N; i++) begin
      serve(p);
      chk($sformatf("rr%0d", i), 32'(p), 32'(i % N));
    end
    port_req = '0;
    chk("rr_cnt", grant_count, 29);
    do_reset;
    prio_mask = N'(1) << 5;
    port_req = (N'(1) << 5) | (N'(1) << 9);
    for (int i = 0; i < 17; i++) begin
      serve(p);
      chk($sformatf("starve%0d", i), 32'(p), (i == 8) ? 32'd9 : 32'd5);
    end
    do_reset;
    port_req = N'(1) << 2;
    step;
    chk("wd_gp", 32'(grant_port), 2);
    port_req = (N'(1) << 2) | (N'(1) << 3);
    k = 0;
    while (!timeout && k < 5000) begin
      step;
      k++;
    end
    chk("wd_cycle", 32'(k), 4096);
    chk("wd_gv", 32'(grant_valid), 0);
    step;
    chk("wd_pulse_end", 32'(timeout), 0);
    chk("wd_next_gp", 32'(grant_port), 3);
    chk("wd_next_gv", 32'(grant_valid), 1);
    for (int i = 0; i < 4095; i++) step;
    frame_done = 1'b1;
    port_req = '0;
    step;
    chk("tie_to", 32'(timeout), 0);
    chk("tie_gv", 32'(grant_valid), 0);
    step;
    frame_done = 1'b0;
    chk("sp_pulse", 32'(spurious_done), 1);
    chk("sp_gv", 32'(grant_valid), 0);
    chk("sp_cnt", grant_count, 2);
    step;
    chk("sp_end", 32'(spurious_done), 0);
    port_req = N'(1) << 7;
    step;
    chk("en_gp", 32'(grant_port), 7);
    port_en = '0;
    port_req = '0;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) step;
    chk("en_hold_gv", 32'(grant_valid), 1);
    chk("en_hold_oh", 32'(grant_onehot), 32'h80);
    frame_done = 1'b1;
    step;
    frame_done = 1'b0;
    chk("en_drop_gv", 32'(grant_valid), 0);
    chk("en_cnt", grant_count, 3);
    port_en = all_ports;
    tx_ready = 1'b1;
    port_req = N'(1) << 10;
    step;
    chk("ar_gv_pre", 32'(grant_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gv", 32'(grant_valid), 0);
    chk("ar_oh", 32'(grant_onehot), 0);
    chk("ar_cnt", grant_count, 0);
    chk("ar_gp", 32'(grant_port), 0);
    step;
    port_req = (N'(1) << 10) | (N'(1) << 20);
    rst_n = 1'b1;
    step;
    chk("ar_restart_gp", 32'(grant_port), 10);
    chk("ar_restart_cnt", grant_count, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
